// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the decode->execute pipeline boundary:
// control-word bit positions and the stage payload layout.
package cpu_pipe_pkg;

    localparam int CTRL_WRE_BIT  = 8;
    localparam int CTRL_VWRE_BIT = 9;
    localparam int CTRL_LOAD_BIT = 7;
    localparam int CTRL_MEMW_BIT = 6;
    localparam int CTRL_WB_LSB   = 4;
    localparam int CTRL_ALU_LSB  = 0;
    localparam int CTRL_WB_W     = 2;
    localparam int CTRL_ALU_W    = 4;
    localparam int CTRL_USED_W   = 10;

    localparam int DE_DATA_W     = 16;
    localparam int DE_REG_ADDR_W = 4;
    localparam int DE_CTRL_W     = 16;

    typedef struct packed {
        logic [DE_CTRL_W-1:0]     ctrl;
        logic [DE_DATA_W-1:0]     srcA;
        logic [DE_DATA_W-1:0]     srcB;
        logic [DE_REG_ADDR_W-1:0] rs1;
        logic [DE_REG_ADDR_W-1:0] rs2;
        logic [DE_REG_ADDR_W-1:0] rd;
    } de_payload_t;

    // Flattened payload width for arbitrary field widths (same field order as de_payload_t).
    function automatic int de_payload_width(input int ctrl_w, input int data_w, input int reg_w);
        return ctrl_w + (2 * data_w) + (3 * reg_w);
    endfunction

endpackage

// File: rtl/pipe_skid_buffer.sv
// Generic two-entry valid/ready skid buffer with flush. The main register
// drives the outputs; the skid register catches an entry while stalled.
module pipe_skid_buffer #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [1:0]           occupancy
);

    logic                 m_valid_r;
    logic                 s_valid_r;
    logic [PAYLOAD_W-1:0] m_data_r;
    logic [PAYLOAD_W-1:0] s_data_r;
    logic                 in_ready_r;
    logic [1:0]           occupancy_r;

    logic                 accept_s;
    logic                 m_free_s;
    logic                 m_valid_nx_s;
    logic                 s_valid_nx_s;
    logic [PAYLOAD_W-1:0] m_data_nx_s;
    logic [PAYLOAD_W-1:0] s_data_nx_s;

    // Next-state selection for main and skid entries; flush drops both.
    always_comb begin
        accept_s     = in_valid && in_ready_r;
        m_free_s     = !m_valid_r || out_ready;
        m_valid_nx_s = m_valid_r;
        s_valid_nx_s = s_valid_r;
        m_data_nx_s  = m_data_r;
        s_data_nx_s  = s_data_r;
        if (flush) begin
            m_valid_nx_s = 1'b0;
            s_valid_nx_s = 1'b0;
        end else if (m_free_s) begin
            if (s_valid_r) begin
                m_data_nx_s  = s_data_r;
                m_valid_nx_s = 1'b1;
                s_valid_nx_s = 1'b0;
            end else if (accept_s) begin
                m_data_nx_s  = in_data;
                m_valid_nx_s = 1'b1;
            end else begin
                m_valid_nx_s = 1'b0;
            end
        end else begin
            if (accept_s) begin
                s_data_nx_s  = in_data;
                s_valid_nx_s = 1'b1;
            end else begin
                s_valid_nx_s = s_valid_r;
            end
        end
    end

    // State registers; in_ready and occupancy are precomputed from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_r   <= 1'b0;
            s_valid_r   <= 1'b0;
            m_data_r    <= {PAYLOAD_W{1'b0}};
            s_data_r    <= {PAYLOAD_W{1'b0}};
            in_ready_r  <= 1'b0;
            occupancy_r <= 2'd0;
        end else begin
            m_valid_r   <= m_valid_nx_s;
            s_valid_r   <= s_valid_nx_s;
            m_data_r    <= m_data_nx_s;
            s_data_r    <= s_data_nx_s;
            in_ready_r  <= !s_valid_nx_s;
            occupancy_r <= {1'b0, m_valid_nx_s} + {1'b0, s_valid_nx_s};
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = m_valid_r;
    assign out_data  = m_data_r;
    assign occupancy = occupancy_r;

endmodule

// File: rtl/decode_execute_stage.sv
// Elastic decode->execute stage: buffers control word, operands and register
// IDs in a skid buffer and presents bubble-gated control fields to execute.
module decode_execute_stage
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int CTRL_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_W-1:0]     nop_mux_output_in,
    input  logic [DATA_W-1:0]     srcA_in,
    input  logic [DATA_W-1:0]     srcB_in,
    input  logic [REG_ADDR_W-1:0] rs1_decode,
    input  logic [REG_ADDR_W-1:0] rs2_decode,
    input  logic [REG_ADDR_W-1:0] rd_decode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  wre_execute,
    output logic                  vector_wre_execute,
    output logic                  load_instruction,
    output logic                  write_memory_enable_execute,
    output logic [1:0]            select_writeback_data_mux_execute,
    output logic [3:0]            aluOp_execute,
    output logic [DATA_W-1:0]     srcA_out,
    output logic [DATA_W-1:0]     srcB_out,
    output logic [REG_ADDR_W-1:0] rs1_execute,
    output logic [REG_ADDR_W-1:0] rs2_execute,
    output logic [REG_ADDR_W-1:0] rd_execute,
    output logic [1:0]            occupancy
);

    localparam int PAYLOAD_W = de_payload_width(CTRL_W, DATA_W, REG_ADDR_W);

    logic [PAYLOAD_W-1:0]  pl_in_s;
    logic [PAYLOAD_W-1:0]  pl_out_s;
    logic [CTRL_W-1:0]     ctrl_s;

    assign pl_in_s = {nop_mux_output_in, srcA_in, srcB_in, rs1_decode, rs2_decode, rd_decode};

    pipe_skid_buffer #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pl_in_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pl_out_s),
        .occupancy (occupancy)
    );

    assign {ctrl_s, srcA_out, srcB_out, rs1_execute, rs2_execute, rd_execute} = pl_out_s;

    // Upper control bits carry no meaning at this stage.
    generate
        if (CTRL_W > CTRL_USED_W) begin : g_ctrl_upper
            logic unused_ctrl_upper_s;
            assign unused_ctrl_upper_s = ^ctrl_s[CTRL_W-1:CTRL_USED_W];
        end
    endgenerate

    // Control fields read as a NOP whenever no valid entry is presented.
    always_comb begin
        wre_execute                       = 1'b0;
        vector_wre_execute                = 1'b0;
        load_instruction                  = 1'b0;
        write_memory_enable_execute       = 1'b0;
        select_writeback_data_mux_execute = 2'b00;
        aluOp_execute                     = 4'h0;
        if (out_valid) begin
            wre_execute                       = ctrl_s[CTRL_WRE_BIT];
            vector_wre_execute                = ctrl_s[CTRL_VWRE_BIT];
            load_instruction                  = ctrl_s[CTRL_LOAD_BIT];
            write_memory_enable_execute       = ctrl_s[CTRL_MEMW_BIT];
            select_writeback_data_mux_execute = ctrl_s[CTRL_WB_LSB +: CTRL_WB_W];
            aluOp_execute                     = ctrl_s[CTRL_ALU_LSB +: CTRL_ALU_W];
        end else begin
            aluOp_execute = 4'h0;
        end
    end

endmodule

// File: tb/tb_decode_execute_stage.sv
// Scoreboard bench for decode_execute_stage: a depth-2 in-order queue model
// predicts acceptance, occupancy and the entry presented to execute.
module tb_decode_execute_stage;

    typedef struct packed {
        logic [15:0] ctrl;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  r1;
        logic [3:0]  r2;
        logic [3:0]  rd;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] nop_mux_output_in, srcA_in, srcB_in, srcA_out, srcB_out;
    logic [3:0]  rs1_decode, rs2_decode, rd_decode, rs1_execute, rs2_execute, rd_execute;
    logic        wre_execute, vector_wre_execute, load_instruction, write_memory_enable_execute;
    logic [1:0]  select_writeback_data_mux_execute, occupancy;
    logic [3:0]  aluOp_execute;

    logic        w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [11:0] w_ctrl;
    logic [31:0] w_srcA, w_srcB, w_srcA_out, w_srcB_out;
    logic [4:0]  w_rs1, w_rs2, w_rd, w_rs1_ex, w_rs2_ex, w_rd_ex;
    logic        w_wre, w_vwre, w_load, w_memw;
    logic [1:0]  w_wb, w_occ;
    logic [3:0]  w_alu;

    ent_t exp_q[$];
    bit   mdl_rdy = 1'b0;
    bit   mon_en  = 1'b0;
    int   checks  = 0;
    int   passes  = 0;
    int   mon_n;
    ent_t mon_e;

    always #5 clk = ~clk;

    decode_execute_stage dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .nop_mux_output_in(nop_mux_output_in), .srcA_in(srcA_in), .srcB_in(srcB_in),
        .rs1_decode(rs1_decode), .rs2_decode(rs2_decode), .rd_decode(rd_decode),
        .out_valid(out_valid), .out_ready(out_ready),
        .wre_execute(wre_execute), .vector_wre_execute(vector_wre_execute),
        .load_instruction(load_instruction),
        .write_memory_enable_execute(write_memory_enable_execute),
        .select_writeback_data_mux_execute(select_writeback_data_mux_execute),
        .aluOp_execute(aluOp_execute), .srcA_out(srcA_out), .srcB_out(srcB_out),
        .rs1_execute(rs1_execute), .rs2_execute(rs2_execute), .rd_execute(rd_execute),
        .occupancy(occupancy)
    );

    decode_execute_stage #(.DATA_W(32), .REG_ADDR_W(5), .CTRL_W(12)) u_wide (
        .clk(clk), .reset(reset), .flush(w_flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .nop_mux_output_in(w_ctrl), .srcA_in(w_srcA), .srcB_in(w_srcB),
        .rs1_decode(w_rs1), .rs2_decode(w_rs2), .rd_decode(w_rd),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .wre_execute(w_wre), .vector_wre_execute(w_vwre), .load_instruction(w_load),
        .write_memory_enable_execute(w_memw), .select_writeback_data_mux_execute(w_wb),
        .aluOp_execute(w_alu), .srcA_out(w_srcA_out), .srcB_out(w_srcB_out),
        .rs1_execute(w_rs1_ex), .rs2_execute(w_rs2_ex), .rd_execute(w_rd_ex),
        .occupancy(w_occ)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic ent_t mk(input logic [15:0] c, input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] rd);
        ent_t e;
        e.ctrl = c; e.a = a; e.b = b; e.r1 = r1; e.r2 = r2; e.rd = rd;
        return e;
    endfunction

    function automatic ent_t rnd_ent();
        return mk(16'($urandom), 16'($urandom), 16'($urandom),
                  4'($urandom), 4'($urandom), 4'($urandom));
    endfunction

    // Monitor: compares what the DUT presents with the queue head; pops on hand-over.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_n = exp_q.size();
            chk("out_valid", {31'd0, out_valid}, (mon_n > 0) ? 32'd1 : 32'd0);
            chk("occupancy", {30'd0, occupancy}, mon_n);
            chk("in_ready", {31'd0, in_ready}, {31'd0, mdl_rdy});
            if (mon_n > 0) begin
                mon_e = exp_q[0];
                chk("ctrl_fields",
                    {20'd0, wre_execute, vector_wre_execute, load_instruction,
                     write_memory_enable_execute, select_writeback_data_mux_execute, aluOp_execute, 2'b00},
                    {20'd0, mon_e.ctrl[8], mon_e.ctrl[9], mon_e.ctrl[7], mon_e.ctrl[6],
                     mon_e.ctrl[5:4], mon_e.ctrl[3:0], 2'b00});
                chk("operands", {srcA_out, srcB_out}, {mon_e.a, mon_e.b});
                chk("reg_ids", {20'd0, rs1_execute, rs2_execute, rd_execute},
                    {20'd0, mon_e.r1, mon_e.r2, mon_e.rd});
                if (out_ready && !flush && !reset) void'(exp_q.pop_front());
            end else begin
                chk("bubble_nop",
                    {22'd0, wre_execute, vector_wre_execute, load_instruction,
                     write_memory_enable_execute, select_writeback_data_mux_execute, aluOp_execute},
                    32'd0);
            end
        end
    end

    // One clock of stimulus; the queue model advances at the active edge.
    task automatic step(input bit iv, input ent_t e, input bit ordy, input bit fl, input bit rst,
                        output bit acc);
        in_valid = iv; nop_mux_output_in = e.ctrl; srcA_in = e.a; srcB_in = e.b;
        rs1_decode = e.r1; rs2_decode = e.r2; rd_decode = e.rd;
        out_ready = ordy; flush = fl; reset = rst;
        acc = iv && mdl_rdy && !fl && !rst;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            mdl_rdy = 1'b0;
        end else if (fl) begin
            exp_q.delete();
            mdl_rdy = 1'b1;
        end else begin
            if (acc) exp_q.push_back(e);
            mdl_rdy = (exp_q.size() < 2);
        end
        #1;
    endtask

    ent_t ea, eb, ec, es;
    bit   acc;

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        nop_mux_output_in = 16'h0; srcA_in = 16'h0; srcB_in = 16'h0;
        rs1_decode = 4'h0; rs2_decode = 4'h0; rd_decode = 4'h0;
        w_flush = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b1; w_ctrl = 12'h0;
        w_srcA = 32'h0; w_srcB = 32'h0; w_rs1 = 5'd0; w_rs2 = 5'd0; w_rd = 5'd0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        step(1'b0, mk(16'h0, 16'h0, 16'h0, 4'h0, 4'h0, 4'h0), 1'b0, 1'b0, 1'b1, acc);
        chk("reset_srcA", {16'd0, srcA_out}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);

        // Streaming with out_ready held high
        es = mk(16'h0185, 16'h1234, 16'h0000, 4'h1, 4'h2, 4'h3);
        step(1'b0, es, 1'b1, 1'b0, 1'b0, acc);
        chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, es, 1'b1, 1'b0, 1'b0, acc);
            chk("stream_wre_load", {30'd0, wre_execute, load_instruction}, 32'd3);
            chk("stream_alu_wb", {26'd0, select_writeback_data_mux_execute, aluOp_execute}, 32'h05);
            chk("stream_occ", {30'd0, occupancy}, 32'd1);
        end
        step(1'b0, es, 1'b1, 1'b0, 1'b0, acc);

        // Stall: A in main, B in skid, C refused until space frees
        ea = rnd_ent(); eb = rnd_ent(); ec = rnd_ent();
        step(1'b1, ea, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, eb, 1'b0, 1'b0, 1'b0, acc);
        chk("stall_occ2", {30'd0, occupancy}, 32'd2);
        chk("stall_not_ready", {31'd0, in_ready}, 32'd0);
        step(1'b1, ec, 1'b0, 1'b0, 1'b0, acc);
        chk("stall_c_refused", {31'd0, acc}, 32'd0);
        chk("stall_holds_a", {16'd0, srcA_out}, {16'd0, ea.a});
        acc = 1'b0;
        for (int i = 0; i < 4 && !acc; i++) step(1'b1, ec, 1'b1, 1'b0, 1'b0, acc);
        chk("stall_c_accepted", {31'd0, acc}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, ec, 1'b1, 1'b0, 1'b0, acc);

        // Flush while full, with an entry offered in the same cycle
        step(1'b1, rnd_ent(), 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, rnd_ent(), 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, rnd_ent(), 1'b1, 1'b1, 1'b0, acc);
        chk("flush_empty", {29'd0, out_valid, occupancy}, 32'd0);
        chk("flush_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_wre", {31'd0, wre_execute}, 32'd0);

        // Reset while full, then resume
        step(1'b1, rnd_ent(), 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, rnd_ent(), 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, rnd_ent(), 1'b0, 1'b0, 1'b1, acc);
        chk("rst_mid_outputs", {srcA_out, 12'd0, rd_execute}, 32'd0);
        chk("rst_mid_valid", {29'd0, out_valid, occupancy}, 32'd0);
        step(1'b0, es, 1'b1, 1'b0, 1'b0, acc);
        step(1'b1, es, 1'b1, 1'b0, 1'b0, acc);
        chk("resume_valid", {31'd0, out_valid}, 32'd1);

        // Vector / memory path
        step(1'b1, mk(16'h0260, 16'h0, 16'h0, 4'h0, 4'h0, 4'h0), 1'b1, 1'b0, 1'b0, acc);
        chk("vec_mem_fields",
            {26'd0, vector_wre_execute, write_memory_enable_execute,
             select_writeback_data_mux_execute, wre_execute, load_instruction},
            32'b11_10_00);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 7, rnd_ent(), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 49) == 0, $urandom_range(0, 149) == 0, acc);
        end
        for (int i = 0; i < 3; i++) step(1'b0, es, 1'b1, 1'b0, 1'b0, acc);
        mon_en = 1'b0;

        // Wide parameterisation: values pass bit-exact
        w_in_valid = 1'b1; w_ctrl = 12'h185; w_srcA = 32'h89ABCDEF; w_srcB = 32'hDEADBEEF;
        w_rs1 = 5'd17; w_rs2 = 5'd31; w_rd = 5'd9;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        chk("wide_valid", {31'd0, w_out_valid}, 32'd1);
        chk("wide_srcB", w_srcB_out, 32'hDEADBEEF);
        chk("wide_srcA", w_srcA_out, 32'h89ABCDEF);
        chk("wide_ids", {17'd0, w_rs1_ex, w_rs2_ex, w_rd_ex}, {17'd0, 5'd17, 5'd31, 5'd9});
        chk("wide_ctrl", {24'd0, w_wre, w_load, w_wb, w_alu}, {24'd0, 8'b1_1_00_0101});
        @(posedge clk); #1;
        chk("wide_bubble", {24'd0, w_out_valid, w_wre, w_load, w_alu, 1'b0}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
